// File: rtl/arb_client_if_if.sv
// Bundles the client-side request/grant and shared-bus signals of arb_client_if.
// master: the front end itself; slave: whatever sits around it (clients and arbiter).
// Pure wiring, no state.
interface arb_client_if_if #(
  parameter int DW = 8
);
  logic [1:3]    start;
  logic [1:3]    g;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [DW-1:0] din3;
  logic [1:3]    r;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [1:0]    owner;
  logic [1:3]    done;
  logic [1:3]    err;
  logic          gerr;

  modport master (
    input  start, g, din1, din2, din3,
    output r, dout, dout_valid, owner, done, err, gerr
  );

  modport slave (
    output start, g, din1, din2, din3,
    input  r, dout, dout_valid, owner, done, err, gerr
  );
endinterface

// File: rtl/arb_client_if.sv
// Turns per-client start pulses into held requests and moves a BURST-word transfer per grant.
// Latency: r one edge after start; first beat one edge after grant is accepted; done with last beat.
// Backpressure: a dropped grant stalls the burst (dout held, count held); extra starts while pending are dropped.
module arb_client_if #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  arb_client_if_if.master bus
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state, state_nx;
  logic [1:3]    pend, pend_nx;
  logic [1:3]    err_q, err_nx;
  logic [1:3]    done_q, done_nx;
  logic [1:0]    owner_q, owner_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DW-1:0] dout_q, dout_nx;
  logic          dv_q, dv_nx;
  logic          gerr_q, gerr_nx;
  logic          gmulti;
  logic          own_g;
  logic          last;
  logic [DW-1:0] din_sel;

  // FSM state register; reset abandons any burst in progress.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state, beat issue, pending/error bookkeeping.
  always_comb begin
    state_nx = state;
    owner_nx = owner_q;
    cnt_nx   = cnt;
    dout_nx  = dout_q;
    dv_nx    = 1'b0;
    done_nx  = '0;
    err_nx   = err_q;
    pend_nx  = pend;
    last     = 1'b0;
    own_g    = 1'b0;
    din_sel  = '0;

    // More than one grant bit is never a valid grant for anyone.
    gmulti  = (bus.g[1] & bus.g[2]) | (bus.g[1] & bus.g[3]) | (bus.g[2] & bus.g[3]);
    gerr_nx = gerr_q | gmulti;

    case (owner_q)
      2'd1:    begin own_g = bus.g[1]; din_sel = bus.din1; end
      2'd2:    begin own_g = bus.g[2]; din_sel = bus.din2; end
      2'd3:    begin own_g = bus.g[3]; din_sel = bus.din3; end
      default: begin own_g = 1'b0;     din_sel = '0;       end
    endcase

    case (state)
      IDLE: begin
        // Only a single-bit grant for a client that is actually pending starts a burst.
        if (!gmulti) begin
          if (bus.g[1] && pend[1]) begin
            state_nx = XFER; owner_nx = 2'd1; cnt_nx = '0;
          end else if (bus.g[2] && pend[2]) begin
            state_nx = XFER; owner_nx = 2'd2; cnt_nx = '0;
          end else if (bus.g[3] && pend[3]) begin
            state_nx = XFER; owner_nx = 2'd3; cnt_nx = '0;
          end
        end
      end
      XFER: begin
        // Losing the grant only stalls; the burst resumes when it comes back.
        if (!gmulti && own_g) begin
          dv_nx   = 1'b1;
          dout_nx = din_sel;
          cnt_nx  = cnt + 1'b1;
          if (cnt == LAST) begin
            last     = 1'b1;
            state_nx = IDLE;
            owner_nx = 2'd0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // A start landing on the owner's last beat re-arms the request instead of erroring.
    for (int i = 1; i <= 3; i++) begin
      if (last && owner_q == 2'(i)) done_nx[i] = 1'b1;
      if (bus.start[i]) begin
        if (!pend[i])                         pend_nx[i] = 1'b1;
        else if (!(last && owner_q == 2'(i))) err_nx[i]  = 1'b1;
      end else if (last && owner_q == 2'(i)) begin
        pend_nx[i] = 1'b0;
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend    <= '0;
      err_q   <= '0;
      done_q  <= '0;
      owner_q <= 2'd0;
      cnt     <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      gerr_q  <= 1'b0;
    end else begin
      pend    <= pend_nx;
      err_q   <= err_nx;
      done_q  <= done_nx;
      owner_q <= owner_nx;
      cnt     <= cnt_nx;
      dout_q  <= dout_nx;
      dv_q    <= dv_nx;
      gerr_q  <= gerr_nx;
    end
  end

  assign bus.r          = pend;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.owner      = owner_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.gerr       = gerr_q;

endmodule
